// File: rtl/regfile_wb_sched_if.sv
// Write-back request, register-file write port, forwarding and status bundle.
// Latency: none, pure signal grouping.
// Backpressure: the producer holds a request until wb_ready is seen high on a rising edge.
interface regfile_wb_sched_if;
  // Write-back request
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic [63:0] valM;
  // Register file write port
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  // Decode-stage forwarding lookup
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic        fwdA_hit;
  logic        fwdB_hit;
  logic [63:0] fwdA_val;
  logic [63:0] fwdB_val;
  // Status
  logic        busy;

  // Request producer / lookup side
  modport master (
    output wb_valid, icode, cnd, dstE, dstM, valE, valM, srcA, srcB,
    input  wb_ready, rf_we, rf_waddr, rf_wdata,
    input  fwdA_hit, fwdB_hit, fwdA_val, fwdB_val, busy
  );

  // Scheduler side
  modport slave (
    input  wb_valid, icode, cnd, dstE, dstM, valE, valM, srcA, srcB,
    output wb_ready, rf_we, rf_waddr, rf_wdata,
    output fwdA_hit, fwdB_hit, fwdA_val, fwdB_val, busy
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Serialises the E and M results of one write-back request onto a single register-file write port.
// Latency: first write registered one cycle after accept; a second write follows on the next cycle.
// Backpressure: wb_ready is high only in IDLE outside reset, so a request blocks for 0, 1 or 2 cycles.
module regfile_wb_sched #(
  parameter logic [3:0] NONE_REG = 4'hF,
  parameter int         NREG     = 15
) (
  input logic             clk,
  input logic             rst,
  regfile_wb_sched_if.slave wb
);

  // Register count widened by one bit so NREG=16 still compares correctly
  localparam logic [4:0] NREG_W = 5'(NREG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_E = 2'd1,
    S_WR_M = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [3:0]  r_waddr;
  logic [63:0] r_wdata;

  // Request fields captured on the accept edge
  logic [3:0]  r_icode;
  logic        r_cnd;
  logic [3:0]  r_dstE;
  logic [3:0]  r_dstM;
  logic [63:0] r_valE;
  logic [63:0] r_valM;

  logic        w_ready;
  logic        w_accept;
  logic        w_in_e_need;
  logic        w_in_m_need;
  logic        w_lat_e_need;
  logic        w_lat_m_need;
  logic        w_pend_e;
  logic        w_pend_m;
  logic        w_fwdA_hit;
  logic        w_fwdB_hit;
  logic [63:0] w_fwdA_val;
  logic [63:0] w_fwdB_val;

  // A destination is writable when it is a real register; out-of-range IDs are dropped.
  function automatic logic f_dst_ok(input logic [3:0] d);
    return (d != NONE_REG) && ({1'b0, d} < NREG_W);
  endfunction

  // E is suppressed for a failed cmovxx and when M targets the same register (valM wins).
  function automatic logic f_e_need(input logic [3:0] ic, input logic c,
                                    input logic [3:0] de, input logic [3:0] dm);
    return f_dst_ok(de) && !((ic == 4'h2) && !c) && (de != dm);
  endfunction

  // Handshake and write-need decode for both the incoming and the latched request
  always_comb begin
    w_ready      = !rst && (r_state == S_IDLE);
    w_accept     = wb.wb_valid && w_ready;
    w_in_e_need  = f_e_need(wb.icode, wb.cnd, wb.dstE, wb.dstM);
    w_in_m_need  = f_dst_ok(wb.dstM);
    w_lat_e_need = f_e_need(r_icode, r_cnd, r_dstE, r_dstM);
    w_lat_m_need = f_dst_ok(r_dstM);
  end

  // Scheduler FSM with registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_waddr <= NONE_REG;
      r_wdata <= 64'd0;
      r_icode <= 4'd0;
      r_cnd   <= 1'b0;
      r_dstE  <= NONE_REG;
      r_dstM  <= NONE_REG;
      r_valE  <= 64'd0;
      r_valM  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (w_accept) begin
            r_icode <= wb.icode;
            r_cnd   <= wb.cnd;
            r_dstE  <= wb.dstE;
            r_dstM  <= wb.dstM;
            r_valE  <= wb.valE;
            r_valM  <= wb.valM;
            if (w_in_e_need) begin
              r_state <= S_WR_E;
              r_we    <= 1'b1;
              r_waddr <= wb.dstE;
              r_wdata <= wb.valE;
            end else if (w_in_m_need) begin
              r_state <= S_WR_M;
              r_we    <= 1'b1;
              r_waddr <= wb.dstM;
              r_wdata <= wb.valM;
            end
          end
        end
        S_WR_E: begin
          if (w_lat_m_need) begin
            r_state <= S_WR_M;
            r_we    <= 1'b1;
            r_waddr <= r_dstM;
            r_wdata <= r_valM;
          end else begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
          end
        end
        S_WR_M: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  // Forwarding over writes not yet retired, including the one on the port this cycle; M beats E
  always_comb begin
    w_pend_e   = !rst && (r_state == S_WR_E) && w_lat_e_need;
    w_pend_m   = !rst && w_lat_m_need &&
                 ((r_state == S_WR_E) || (r_state == S_WR_M));
    w_fwdA_hit = 1'b0;
    w_fwdA_val = 64'd0;
    w_fwdB_hit = 1'b0;
    w_fwdB_val = 64'd0;
    if (wb.srcA != NONE_REG) begin
      if (w_pend_m && (wb.srcA == r_dstM)) begin
        w_fwdA_hit = 1'b1;
        w_fwdA_val = r_valM;
      end else if (w_pend_e && (wb.srcA == r_dstE)) begin
        w_fwdA_hit = 1'b1;
        w_fwdA_val = r_valE;
      end
    end
    if (wb.srcB != NONE_REG) begin
      if (w_pend_m && (wb.srcB == r_dstM)) begin
        w_fwdB_hit = 1'b1;
        w_fwdB_val = r_valM;
      end else if (w_pend_e && (wb.srcB == r_dstE)) begin
        w_fwdB_hit = 1'b1;
        w_fwdB_val = r_valE;
      end
    end
  end

  assign wb.wb_ready = w_ready;
  assign wb.busy     = !rst && (r_state != S_IDLE);
  assign wb.rf_we    = r_we;
  assign wb.rf_waddr = r_waddr;
  assign wb.rf_wdata = r_wdata;
  assign wb.fwdA_hit = w_fwdA_hit;
  assign wb.fwdB_hit = w_fwdB_hit;
  assign wb.fwdA_val = w_fwdA_val;
  assign wb.fwdB_val = w_fwdB_val;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for the write-back scheduler: hand-computed expectations checked at negedges.
// Latency: inputs change on negedges, outputs are sampled on the following negedge.
// Backpressure: requests are only issued when wb_ready is expected high.
module tb_regfile_wb_sched;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_wb_sched_if bus ();
  regfile_wb_sched_if bus8 ();

  regfile_wb_sched u_dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  // Second instance with only 8 registers so out-of-range destinations exist
  regfile_wb_sched #(.NREG(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .wb  (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; returns at the following negedge with wb_valid low
  task automatic req(input logic [3:0] ic, input logic c, input logic [3:0] de,
                     input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    bus.icode    = ic;
    bus.cnd      = c;
    bus.dstE     = de;
    bus.dstM     = dm;
    bus.valE     = ve;
    bus.valM     = vm;
    bus.wb_valid = 1'b1;
    @(negedge clk);
    bus.wb_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] a, input logic [63:0] d);
    chk({tag, ".we"},   bus.rf_we,    we);
    chk({tag, ".addr"}, bus.rf_waddr, a);
    chk({tag, ".data"}, bus.rf_wdata, d);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.icode = 4'h0; bus.cnd = 1'b0;
    bus.dstE = 4'hF; bus.dstM = 4'hF; bus.valE = 64'd0; bus.valM = 64'd0;
    bus.srcA = 4'hF; bus.srcB = 4'hF;
    bus8.wb_valid = 1'b0; bus8.icode = 4'h0; bus8.cnd = 1'b0;
    bus8.dstE = 4'hF; bus8.dstM = 4'hF; bus8.valE = 64'd0; bus8.valM = 64'd0;
    bus8.srcA = 4'hF; bus8.srcB = 4'hF;

    // Reset state, with a request offered that must be ignored
    bus.wb_valid = 1'b1; bus.dstE = 4'h3;
    @(negedge clk);
    @(negedge clk);
    chk_wr("rst", 1'b0, 4'hF, 64'd0);
    chk("rst.ready", bus.wb_ready, 1'b0);
    chk("rst.busy",  bus.busy,     1'b0);
    bus.wb_valid = 1'b0; bus.dstE = 4'hF;
    bus.srcA = 4'h3; #1;
    chk("rst.fwdA_hit", bus.fwdA_hit, 1'b0);
    rst = 1'b0; #1;
    chk("idle.ready", bus.wb_ready, 1'b1);
    chk("idle.busy",  bus.busy,     1'b0);

    // OPq: one E write
    req(4'h6, 1'b1, 4'h3, 4'hF, 64'h10, 64'h0);
    chk_wr("opq.c1", 1'b1, 4'h3, 64'h10);
    chk("opq.c1.ready", bus.wb_ready, 1'b0);
    chk("opq.c1.busy",  bus.busy,     1'b1);
    chk("opq.c1.fwdA_hit", bus.fwdA_hit, 1'b1);
    chk("opq.c1.fwdA_val", bus.fwdA_val, 64'h10);
    @(negedge clk);
    chk_wr("opq.c2", 1'b0, 4'h3, 64'h10);
    chk("opq.c2.ready", bus.wb_ready, 1'b1);
    chk("opq.c2.fwdA_hit", bus.fwdA_hit, 1'b0);
    chk("opq.c2.fwdA_val", bus.fwdA_val, 64'h0);

    // popq: E then M, forwarding during the E cycle
    req(4'hB, 1'b1, 4'h4, 4'h7, 64'h28, 64'hAB);
    bus.srcA = 4'h7; bus.srcB = 4'h4; #1;
    chk_wr("pop.c1", 1'b1, 4'h4, 64'h28);
    chk("pop.c1.ready", bus.wb_ready, 1'b0);
    chk("pop.c1.fwdA_hit", bus.fwdA_hit, 1'b1);
    chk("pop.c1.fwdA_val", bus.fwdA_val, 64'hAB);
    chk("pop.c1.fwdB_hit", bus.fwdB_hit, 1'b1);
    chk("pop.c1.fwdB_val", bus.fwdB_val, 64'h28);
    @(negedge clk);
    chk_wr("pop.c2", 1'b1, 4'h7, 64'hAB);
    chk("pop.c2.ready", bus.wb_ready, 1'b0);
    chk("pop.c2.fwdA_val", bus.fwdA_val, 64'hAB);
    chk("pop.c2.fwdB_hit", bus.fwdB_hit, 1'b0);
    chk("pop.c2.fwdB_val", bus.fwdB_val, 64'h0);
    @(negedge clk);
    chk("pop.c3.we",    bus.rf_we,    1'b0);
    chk("pop.c3.ready", bus.wb_ready, 1'b1);
    chk("pop.c3.fwdA_hit", bus.fwdA_hit, 1'b0);

    // popq %rsp: same destination, only valM is written; NONE source never hits
    req(4'hB, 1'b1, 4'h4, 4'h4, 64'h30, 64'h99);
    bus.srcA = 4'h4; bus.srcB = 4'hF; #1;
    chk_wr("rsp.c1", 1'b1, 4'h4, 64'h99);
    chk("rsp.c1.fwdA_val", bus.fwdA_val, 64'h99);
    chk("rsp.c1.fwdB_hit", bus.fwdB_hit, 1'b0);
    @(negedge clk);
    chk("rsp.c2.we",    bus.rf_we,    1'b0);
    chk("rsp.c2.ready", bus.wb_ready, 1'b1);
    bus.srcA = 4'hF;

    // cmovxx not taken: no write, ready stays high, address holds
    req(4'h2, 1'b0, 4'h5, 4'hF, 64'h55, 64'h0);
    chk_wr("cmov0.c1", 1'b0, 4'h4, 64'h99);
    chk("cmov0.c1.ready", bus.wb_ready, 1'b1);
    chk("cmov0.c1.busy",  bus.busy,     1'b0);
    // cmovxx taken
    req(4'h2, 1'b1, 4'h5, 4'hF, 64'h55, 64'h0);
    chk_wr("cmov1.c1", 1'b1, 4'h5, 64'h55);
    @(negedge clk);
    chk("cmov1.c2.we", bus.rf_we, 1'b0);

    // Highest legal register with only an M destination
    req(4'h5, 1'b1, 4'hF, 4'hE, 64'h0, 64'hE1);
    chk_wr("r14.c1", 1'b1, 4'hE, 64'hE1);
    @(negedge clk);
    chk("r14.c2.ready", bus.wb_ready, 1'b1);

    // Reset during the E write of a two-write request aborts the M write
    req(4'hB, 1'b1, 4'h1, 4'h2, 64'h11, 64'h22);
    chk_wr("abort.c1", 1'b1, 4'h1, 64'h11);
    rst = 1'b1;
    @(negedge clk);
    bus.srcA = 4'h2; #1;
    chk_wr("abort.c2", 1'b0, 4'hF, 64'd0);
    chk("abort.c2.ready", bus.wb_ready, 1'b0);
    chk("abort.c2.busy",  bus.busy,     1'b0);
    chk("abort.c2.fwdA_hit", bus.fwdA_hit, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort.c3.we",    bus.rf_we,    1'b0);
    chk("abort.c3.ready", bus.wb_ready, 1'b1);
    bus.srcA = 4'hF;
    req(4'h6, 1'b1, 4'h6, 4'hF, 64'h66, 64'h0);
    chk_wr("post.c1", 1'b1, 4'h6, 64'h66);
    @(negedge clk);

    // Back-to-back with wb_valid held: B waits for IDLE after A's two writes
    bus.icode = 4'hB; bus.cnd = 1'b1; bus.dstE = 4'h1; bus.dstM = 4'h2;
    bus.valE = 64'hA1; bus.valM = 64'hA2; bus.wb_valid = 1'b1;
    @(negedge clk);
    chk_wr("b2b.c1", 1'b1, 4'h1, 64'hA1);
    bus.icode = 4'h6; bus.dstE = 4'h3; bus.dstM = 4'hF; bus.valE = 64'hB3; bus.valM = 64'h0;
    @(negedge clk);
    chk_wr("b2b.c2", 1'b1, 4'h2, 64'hA2);
    @(negedge clk);
    chk("b2b.c3.we",    bus.rf_we,    1'b0);
    chk("b2b.c3.ready", bus.wb_ready, 1'b1);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    chk_wr("b2b.c4", 1'b1, 4'h3, 64'hB3);
    @(negedge clk);
    chk("b2b.c5.we",    bus.rf_we,    1'b0);
    chk("b2b.c5.ready", bus.wb_ready, 1'b1);

    // NREG=8: illegal E destination dropped, legal M still written
    bus8.icode = 4'h5; bus8.cnd = 1'b1; bus8.dstE = 4'h9; bus8.dstM = 4'h2;
    bus8.valE = 64'h99; bus8.valM = 64'h22; bus8.wb_valid = 1'b1;
    @(negedge clk);
    bus8.wb_valid = 1'b0;
    bus8.srcA = 4'h9; #1;
    chk("ill.c1.we",   bus8.rf_we,    1'b1);
    chk("ill.c1.addr", bus8.rf_waddr, 4'h2);
    chk("ill.c1.data", bus8.rf_wdata, 64'h22);
    chk("ill.c1.fwdA_hit", bus8.fwdA_hit, 1'b0);
    @(negedge clk);
    chk("ill.c2.we",    bus8.rf_we,    1'b0);
    chk("ill.c2.ready", bus8.wb_ready, 1'b1);
    // Illegal M with no E: nothing written, never busy
    bus8.dstE = 4'hF; bus8.dstM = 4'h9; bus8.wb_valid = 1'b1;
    @(negedge clk);
    bus8.wb_valid = 1'b0;
    chk("ill2.c1.we",    bus8.rf_we,    1'b0);
    chk("ill2.c1.ready", bus8.wb_ready, 1'b1);
    chk("ill2.c1.addr",  bus8.rf_waddr, 4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
